sys_latch_bank: RTL and testbench

- Parametrised, clocked successor to the board system latch: a WIDTH-bit addressable control-latch bank written by 68k write strobes.
- Each strobe selects one bit via SEL and carries its value on D.
- Supports per-bit reset values, per-bit write protection, four write modes (latch/demux/clear/hold), strobe synchronisation and single-write-per-strobe qualification.
- Reports every committed write with an acknowledge pulse and a toggle mask; sits between the 68k address decode and the system control signals (shadow, vector, card, SRAM, palette bank…).

---
 rtl/sys_latch_bank.sv | 100 ++++++++++
 tb/tb_sys_latch_bank.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_latch_bank.sv
// Addressable control-latch bank written by asynchronous 68k write strobes.
// Each committed write is reported with a one-cycle acknowledge and a toggle mask.
module sys_latch_bank #(
  parameter int unsigned SEL_W = 3,
  localparam int unsigned WIDTH = 2**SEL_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] WR_MASK = '1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK_24M,
  input  logic             nRESET,
  input  logic [SEL_W-1:0] SEL,
  input  logic             D,
  input  logic [1:0]       MODE,
  input  logic             nWR,
  output logic [WIDTH-1:0] Q,
  output logic             WR_ACK,
  output logic             CHANGED,
  output logic [WIDTH-1:0] CHG_MASK
);

  typedef enum logic [1:0] {
    MODE_LATCH = 2'b00,
    MODE_DEMUX = 2'b01,
    MODE_CLEAR = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(MODE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   synced;
  logic                   filled;
  logic                   hist_q;
  logic                   armed;
  logic                   ev_q;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filled = fill_q[SYNC_STAGES-1];

  // fill_q marks when synced carries a real nWR sample rather than the reset-forced 1,
  // so a strobe already low at reset release can never arm the detector.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      sync_q <= '1;
      fill_q <= '0;
      hist_q <= 1'b1;
      armed  <= 1'b0;
      ev_q   <= 1'b0;
    end else begin
      sync_q[0] <= nWR;
      fill_q[0] <= 1'b1;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
        fill_q[i] <= fill_q[i-1];
      end
      hist_q <= synced;
      armed  <= armed | (filled & synced);
      ev_q   <= armed & hist_q & ~synced;
    end
  end

  logic [WIDTH-1:0] sel_hot;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] q_new;

  always_comb begin
    sel_hot      = '0;
    sel_hot[SEL] = 1'b1;
    q_raw        = Q;
    unique case (mode)
      MODE_LATCH: q_raw[SEL] = D;
      MODE_DEMUX: q_raw = sel_hot & {WIDTH{D}};
      MODE_CLEAR: q_raw = '0;
      MODE_HOLD:  q_raw = Q;
    endcase
    q_new = (q_raw & WR_MASK) | (RESET_VAL & ~WR_MASK);
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      Q        <= RESET_VAL;
      WR_ACK   <= 1'b0;
      CHANGED  <= 1'b0;
      CHG_MASK <= '0;
    end else if (ev_q) begin
      Q        <= q_new;
      WR_ACK   <= 1'b1;
      CHANGED  <= |(Q ^ q_new);
      CHG_MASK <= Q ^ q_new;
    end else begin
      WR_ACK   <= 1'b0;
      CHANGED  <= 1'b0;
      CHG_MASK <= '0;
    end
  end

endmodule

// File: tb/tb_sys_latch_bank.sv
// Bench for sys_latch_bank: four configurations share one strobe stream and are
// checked every cycle against a history-based model plus directed literal checks.
module tb_sys_latch_bank;

  logic       CLK_24M = 1'b0;
  logic       nRESET  = 1'b0;
  logic [3:0] SEL     = '0;
  logic       D       = 1'b0;
  logic [1:0] MODE    = '0;
  logic       nWR     = 1'b1;

  always #5 CLK_24M = ~CLK_24M;

  localparam int          WW [4] = '{8, 8, 16, 16};
  localparam int          SS [4] = '{2, 2, 1, 3};
  localparam logic [15:0] RV [4] = '{16'h0041, 16'h0080, 16'h0000, 16'h0000};
  localparam logic [15:0] WM [4] = '{16'h00FF, 16'h007F, 16'hFFFF, 16'hFFFF};

  logic [7:0]  q0, q1, cm0, cm1;
  logic [15:0] q2, q3, cm2, cm3;
  logic        a0, a1, a2, a3, c0, c1, c2, c3;

  sys_latch_bank #(.SEL_W(3), .RESET_VAL(8'h41), .WR_MASK(8'hFF), .SYNC_STAGES(2)) u0 (
    .CLK_24M(CLK_24M), .nRESET(nRESET), .SEL(SEL[2:0]), .D(D), .MODE(MODE), .nWR(nWR),
    .Q(q0), .WR_ACK(a0), .CHANGED(c0), .CHG_MASK(cm0));
  sys_latch_bank #(.SEL_W(3), .RESET_VAL(8'h80), .WR_MASK(8'h7F), .SYNC_STAGES(2)) u1 (
    .CLK_24M(CLK_24M), .nRESET(nRESET), .SEL(SEL[2:0]), .D(D), .MODE(MODE), .nWR(nWR),
    .Q(q1), .WR_ACK(a1), .CHANGED(c1), .CHG_MASK(cm1));
  sys_latch_bank #(.SEL_W(4), .SYNC_STAGES(1)) u2 (
    .CLK_24M(CLK_24M), .nRESET(nRESET), .SEL(SEL), .D(D), .MODE(MODE), .nWR(nWR),
    .Q(q2), .WR_ACK(a2), .CHANGED(c2), .CHG_MASK(cm2));
  sys_latch_bank #(.SEL_W(4), .SYNC_STAGES(3)) u3 (
    .CLK_24M(CLK_24M), .nRESET(nRESET), .SEL(SEL), .D(D), .MODE(MODE), .nWR(nWR),
    .Q(q3), .WR_ACK(a3), .CHANGED(c3), .CHG_MASK(cm3));

  logic [15:0] dq [4];
  logic [15:0] dm [4];
  logic        dack [4];
  logic        dchg [4];
  assign dq[0] = {8'h00, q0};  assign dq[1] = {8'h00, q1};  assign dq[2] = q2;  assign dq[3] = q3;
  assign dm[0] = {8'h00, cm0}; assign dm[1] = {8'h00, cm1}; assign dm[2] = cm2; assign dm[3] = cm3;
  assign dack[0] = a0; assign dack[1] = a1; assign dack[2] = a2; assign dack[3] = a3;
  assign dchg[0] = c0; assign dchg[1] = c1; assign dchg[2] = c2; assign dchg[3] = c3;

  // Model: a write commits S+1 edges after the first low sample of nWR, provided the
  // preceding sample was a genuine high taken since reset release.
  logic [15:0] m_q [4] = RV;
  logic [15:0] m_mask [4] = '{default: '0};
  logic        m_ack [4] = '{default: 1'b0};
  logic        m_chg [4] = '{default: 1'b0};
  logic [63:0] hist = '1;
  int          nval = 0;

  function automatic logic [15:0] next_q(input int i, input logic [15:0] q, input logic [3:0] sel,
                                         input logic d, input logic [1:0] m);
    logic [15:0] bitv, nv, full;
    int sidx;
    sidx = int'(sel) % WW[i];
    bitv = 16'd1 << sidx;
    full = (WW[i] == 16) ? 16'hFFFF : 16'h00FF;
    case (m)
      2'b00:   nv = d ? (q | bitv) : (q & ~bitv);
      2'b01:   nv = d ? bitv : 16'h0000;
      2'b10:   nv = 16'h0000;
      default: nv = q;
    endcase
    return ((nv & WM[i]) | (RV[i] & ~WM[i])) & full;
  endfunction

  always @(posedge CLK_24M or negedge nRESET) begin : model
    logic [15:0] nq;
    int s;
    if (!nRESET) begin
      hist = '1;
      nval = 0;
      for (int i = 0; i < 4; i++) begin
        m_q[i] = RV[i]; m_mask[i] = '0; m_ack[i] = 1'b0; m_chg[i] = 1'b0;
      end
    end else begin
      hist = {hist[62:0], nWR};
      if (nval < 63) nval++;
      for (int i = 0; i < 4; i++) begin
        s = SS[i];
        if (nval >= s + 3 && hist[s+1] == 1'b0 && hist[s+2] == 1'b1) begin
          nq = next_q(i, m_q[i], SEL, D, MODE);
          m_mask[i] = m_q[i] ^ nq;
          m_chg[i]  = |m_mask[i];
          m_ack[i]  = 1'b1;
          m_q[i]    = nq;
        end else begin
          m_mask[i] = '0; m_chg[i] = 1'b0; m_ack[i] = 1'b0;
        end
      end
    end
  end

  int          pass_cnt = 0;
  int          tot_cnt  = 0;
  int          tcnt     = 0;
  int          acks [4];
  int          lat [4];
  logic        last_chg [4];
  logic [15:0] last_mask [4];
  logic [15:0] prev_q [4];

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
  endtask

  task automatic tick();
    @(negedge CLK_24M);
    tcnt++;
    for (int i = 0; i < 4; i++) begin
      chk("q", i, dq[i], m_q[i]);
      chk("ack", i, 16'(dack[i]), 16'(m_ack[i]));
      chk("changed", i, 16'(dchg[i]), 16'(m_chg[i]));
      chk("chg_mask", i, dm[i], m_mask[i]);
      if (dack[i]) begin
        acks[i]++; last_chg[i] = dchg[i]; last_mask[i] = dm[i];
      end
      if (lat[i] < 0 && dq[i] !== prev_q[i]) lat[i] = tcnt - 1;
      prev_q[i] = dq[i];
    end
  endtask

  task automatic clr();
    tcnt = 0;
    for (int i = 0; i < 4; i++) begin
      acks[i] = 0; lat[i] = -1; last_chg[i] = 1'bx; last_mask[i] = 'x; prev_q[i] = dq[i];
    end
  endtask

  task automatic strobe(input logic [3:0] s, input logic d, input logic [1:0] m, input int lo, input int hi);
    SEL = s; D = d; MODE = m; nWR = 1'b0;
    clr();
    repeat (lo) tick();
    nWR = 1'b1;
    repeat (hi) tick();
  endtask

  initial begin
    clr();
    repeat (3) tick();
    chk("rst_q", 0, dq[0], 16'h0041);
    chk("rst_q", 1, dq[1], 16'h0080);
    chk("rst_q", 2, dq[2], 16'h0000);
    chk("rst_ack", 0, 16'(dack[0]), 16'h0000);
    nRESET = 1'b1;
    repeat (4) tick();
    chk("rel_q", 0, dq[0], 16'h0041);

    strobe(4'd0, 1'b0, 2'b10, 6, 6);
    chk("clr_q", 0, dq[0], 16'h0000);
    chk("clr_q", 1, dq[1], 16'h0080);

    // Latch SEL=3 with cycle-exact latency per configuration.
    SEL = 4'd3; D = 1'b1; MODE = 2'b00; nWR = 1'b0;
    clr();
    for (int c = 0; c < 6; c++) begin
      tick();
      case (c)
        0: chk("lat_q_k", 0, dq[0], 16'h0000);
        1: chk("lat_q_k1", 2, dq[2], 16'h0000);
        2: begin
          chk("lat_q_k2", 0, dq[0], 16'h0000);
          chk("lat_q_k2", 2, dq[2], 16'h0008);
        end
        3: begin
          chk("lat_q_k3", 0, dq[0], 16'h0008);
          chk("lat_ack", 0, 16'(dack[0]), 16'h0001);
          chk("lat_mask", 0, dm[0], 16'h0008);
          chk("lat_chg", 0, 16'(dchg[0]), 16'h0001);
          chk("lat_q_k3", 3, dq[3], 16'h0000);
        end
        4: begin
          chk("lat_q_k4", 3, dq[3], 16'h0008);
          chk("ack_off", 0, 16'(dack[0]), 16'h0000);
        end
        default: ;
      endcase
    end
    nWR = 1'b1;
    repeat (6) tick();
    chk("one_ack", 0, 16'(acks[0]), 16'd1);

    strobe(4'd3, 1'b1, 2'b00, 6, 6);
    chk("same_ack", 0, 16'(acks[0]), 16'd1);
    chk("same_chg", 0, 16'(last_chg[0]), 16'h0000);
    chk("same_mask", 0, last_mask[0], 16'h0000);

    strobe(4'd4, 1'b1, 2'b00, 6, 6);
    strobe(4'd5, 1'b1, 2'b00, 6, 6);
    strobe(4'd6, 1'b1, 2'b00, 6, 6);
    strobe(4'd7, 1'b1, 2'b00, 6, 6);
    strobe(4'd3, 1'b0, 2'b00, 6, 6);
    chk("f0_q", 0, dq[0], 16'h00F0);
    strobe(4'd1, 1'b1, 2'b01, 6, 6);
    chk("demux_q", 0, dq[0], 16'h0002);
    chk("demux_mask", 0, last_mask[0], 16'h00F2);
    chk("demux_q", 1, dq[1], 16'h0082);
    strobe(4'd0, 1'b0, 2'b10, 6, 6);
    chk("clear_q", 0, dq[0], 16'h0000);
    chk("clear_mask", 0, last_mask[0], 16'h0002);
    chk("clear_q", 1, dq[1], 16'h0080);
    strobe(4'd5, 1'b1, 2'b11, 6, 6);
    chk("hold_ack", 0, 16'(acks[0]), 16'd1);
    chk("hold_q", 0, dq[0], 16'h0000);

    strobe(4'd0, 1'b1, 2'b01, 6, 6);
    chk("prot_demux", 1, dq[1], 16'h0081);
    strobe(4'd0, 1'b0, 2'b10, 6, 6);
    chk("prot_clear", 1, dq[1], 16'h0080);
    strobe(4'd7, 1'b0, 2'b00, 6, 6);
    chk("prot_latch", 1, dq[1], 16'h0080);
    chk("prot_ack", 1, 16'(acks[1]), 16'd1);
    chk("prot_chg", 1, 16'(last_chg[1]), 16'h0000);

    strobe(4'd15, 1'b1, 2'b00, 6, 6);
    chk("sweep_q", 2, dq[2], 16'h8000);
    chk("sweep_q", 3, dq[3], 16'h8000);
    chk("sweep_lat", 2, 16'(lat[2]), 16'd2);
    chk("sweep_lat", 3, 16'(lat[3]), 16'd4);
    chk("sweep_q", 0, dq[0], 16'h0080);
    chk("sweep_lat", 0, 16'(lat[0]), 16'd3);

    // Strobe already low when reset releases.
    nWR = 1'b0;
    nRESET = 1'b0;
    repeat (2) tick();
    nRESET = 1'b1;
    clr();
    repeat (10) tick();
    chk("lowrel_acks", 0, 16'(acks[0]), 16'd0);
    chk("lowrel_q", 0, dq[0], 16'h0041);
    nWR = 1'b1;
    repeat (4) tick();
    strobe(4'd0, 1'b0, 2'b00, 6, 6);
    chk("rearm_acks", 0, 16'(acks[0]), 16'd1);
    chk("rearm_q", 0, dq[0], 16'h0040);

    MODE = 2'b11;
    clr();
    nWR = 1'b0; repeat (6) tick();
    nWR = 1'b1; tick();
    nWR = 1'b0; repeat (6) tick();
    nWR = 1'b1; repeat (6) tick();
    chk("b2b_acks", 0, 16'(acks[0]), 16'd2);
    chk("b2b_acks", 2, 16'(acks[2]), 16'd2);
    chk("b2b_acks", 3, 16'(acks[3]), 16'd2);

    strobe(4'd0, 1'b0, 2'b11, 50, 6);
    chk("long_acks", 0, 16'(acks[0]), 16'd1);

    // Reset asserted mid-strobe, released while nWR is still low.
    SEL = 4'd2; D = 1'b1; MODE = 2'b00; nWR = 1'b0;
    tick(); tick();
    @(posedge CLK_24M);
    #2 nRESET = 1'b0;
    #1;
    chk("midrst_q", 0, dq[0], 16'h0041);
    chk("midrst_ack", 0, 16'(dack[0]), 16'h0000);
    chk("midrst_q", 1, dq[1], 16'h0080);
    repeat (2) tick();
    nRESET = 1'b1;
    clr();
    repeat (10) tick();
    chk("midrst_acks", 0, 16'(acks[0]), 16'd0);
    chk("midrst_hold", 0, dq[0], 16'h0041);
    nWR = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
